// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite bus types and slave state encoding
//
// Purpose: bus-level enums (HTRANS, HBURST, HRESP), the size/direction
// constants used by masters and slaves, and the memory slave FSM states.
// Ports: none (package).

package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001
  } HBURST_Type;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_state;

  localparam logic [2:0] WORD = 3'b010;
  localparam logic       READ = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slave_state;

endpackage

// File: rtl/ahb3lite_sram_1rw.sv
// rtl/ahb3lite_sram_1rw.sv - word RAM with synchronous write and combinational read
//
// Purpose: backing store for the AHB memory slave. Contents are not reset.
// Ports:
//   clk   in  : write clock
//   we    in  : write enable, commits wdata to mem[waddr] at the rising edge
//   waddr in  : write word index
//   wdata in  : write data
//   raddr in  : read word index
//   rdata out : mem[raddr], combinational (the slave registers it)

module ahb3lite_sram_1rw #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb3lite_slave_mem.sv
// rtl/ahb3lite_slave_mem.sv - AHB3-Lite memory slave with wait states and ERROR response
//
// Purpose: decodes AHB address phases, checks legality, inserts WAIT_STATES
// HREADY-low cycles per OKAY transfer, serves word reads/writes from a RAM,
// and produces the two-cycle ERROR response for illegal accesses.
// Ports:
//   HCLK      in  : bus clock
//   HRESET    in  : asynchronous active-high reset
//   HSEL      in  : slave select
//   HADDR     in  : byte address
//   HTRANS    in  : transfer type
//   HWRITE    in  : 1 = write, 0 = read
//   HSIZE     in  : transfer size (word only)
//   HBURST    in  : burst type (informational)
//   HWDATA    in  : write data (data phase)
//   HREADY    out : slave ready / transfer complete
//   HRDATA    out : registered read data
//   HRDATA_En out : one-cycle strobe marking valid HRDATA
//   HRESP     out : OKAY / ERROR

module ahb3lite_slave_mem
  import ahb3lite_pkg::*;
#(
  parameter int          MEM_DEPTH   = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  HTRANS_state HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  HBURST_Type  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRDATA_En,
  output HRESP_state  HRESP
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [32:0] SPAN      = 33'(MEM_DEPTH * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic        write_q, write_d;
  logic        hready_q, hready_d;
  HRESP_state  hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        hrdata_en_q, hrdata_en_d;

  logic [32:0]   diff;
  logic          legal;
  logic          accept;
  logic [AW-1:0] addr_idx;
  logic          mem_we;
  logic          bypass;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;

  // 33-bit difference: an address below BASE_ADDR wraps to a value with
  // bit 32 set, which is always >= SPAN, so one compare covers both bounds.
  assign diff     = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign legal    = (HSIZE == WORD) && (HADDR[1:0] == 2'b00) && (diff < SPAN);
  assign accept   = hready_q && HSEL && ((HTRANS == NONSEQ) || (HTRANS == SEQ));
  assign addr_idx = diff[AW+1:2];

  // Write of the transfer currently in its data phase commits at this edge.
  assign mem_we = (state_q == S_DATA) && write_q;
  // A read accepted in the same cycle as a write to the same word must see
  // the new data; the RAM only holds it after the edge.
  assign bypass = mem_we && (idx_q == addr_idx);
  // Waited reads fetch the latched index; zero-wait reads fetch the index
  // being accepted so the data is registered at the acceptance edge.
  assign raddr  = (state_q == S_WAIT) ? idx_q : addr_idx;

  ahb3lite_sram_1rw #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (HCLK),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (HWDATA),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    hrdata_d    = hrdata_q;
    hrdata_en_d = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          if (write_q == READ) begin
            hrdata_d    = rdata;
            hrdata_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        // S_IDLE, S_DATA, S_ERR2: HREADY is high, a new address phase may land.
        if (accept) begin
          if (legal) begin
            idx_d   = addr_idx;
            write_d = HWRITE;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = S_DATA;
              if (HWRITE == READ) begin
                hrdata_d    = bypass ? HWDATA : rdata;
                hrdata_en_d = 1'b1;
              end
            end
          end else begin
            state_d = S_ERR1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    hready_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? ERROR : OKAY;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      hready_q    <= 1'b1;
      hresp_q     <= OKAY;
      hrdata_q    <= 32'd0;
      hrdata_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      hready_q    <= hready_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      hrdata_en_q <= hrdata_en_d;
    end
  end

  assign HREADY    = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign HRDATA_En = hrdata_en_q;

  // HBURST carries no behaviour here; bursts are served beat by beat.
  logic unused_ok;
  assign unused_ok = ^{HBURST, diff[1:0]};

endmodule

// File: tb/tb_ahb3lite_slave_mem.sv
// tb/tb_ahb3lite_slave_mem.sv - directed self-checking bench for ahb3lite_slave_mem

module tb_ahb3lite_slave_mem;
  import ahb3lite_pkg::*;

  logic        HCLK   = 1'b0;
  logic        HRESET = 1'b1;
  logic        sel0   = 1'b0;
  logic        sel2   = 1'b0;
  logic [31:0] HADDR  = 32'd0;
  logic [31:0] HWDATA = 32'd0;
  HTRANS_state HTRANS = IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE  = WORD;
  HBURST_Type  HBURST = SINGLE;

  logic        hready0, en0;
  logic [31:0] hrdata0;
  HRESP_state  hresp0;
  logic        hready2, en2;
  logic [31:0] hrdata2;
  HRESP_state  hresp2;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_slave_mem #(.MEM_DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_w0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(hready0), .HRDATA(hrdata0), .HRDATA_En(en0), .HRESP(hresp0)
  );

  ahb3lite_slave_mem #(.MEM_DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_w2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(hready2), .HRDATA(hrdata2), .HRDATA_En(en2), .HRESP(hresp2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of bus inputs just after the next rising edge.
  task automatic bus(input logic s0, input logic s2, input HTRANS_state t, input logic w,
                     input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    @(posedge HCLK);
    #1;
    sel0   = s0;
    sel2   = s2;
    HTRANS = t;
    HWRITE = w;
    HADDR  = a;
    HSIZE  = sz;
    HWDATA = wd;
  endtask

  logic [31:0] bad_addr [3];
  logic [2:0]  bad_size [3];

  initial begin
    bad_addr[0] = 32'h100; bad_size[0] = WORD;
    bad_addr[1] = 32'h002; bad_size[1] = WORD;
    bad_addr[2] = 32'h000; bad_size[2] = 3'b001;

    repeat (2) @(negedge HCLK);
    chk("rst_hready0", 32'(hready0), 1);
    chk("rst_hresp0",  32'(hresp0),  32'(OKAY));
    chk("rst_hrdata0", hrdata0,      0);
    chk("rst_en0",     32'(en0),     0);
    chk("rst_hready2", 32'(hready2), 1);
    HRESET = 1'b0;

    // W=0: write then immediate read of the same word (bypass path)
    bus(1'b1, 1'b0, NONSEQ, 1'b1, 32'h10, WORD, 32'd0);
    bus(1'b1, 1'b0, NONSEQ, 1'b0, 32'h10, WORD, 32'hDEAD_BEEF);
    @(negedge HCLK);
    chk("wr_dphase_hready", 32'(hready0), 1);
    chk("wr_dphase_en",     32'(en0),     0);
    bus(1'b1, 1'b0, IDLE, 1'b0, 32'h0, WORD, 32'd0);
    @(negedge HCLK);
    chk("raw_data",   hrdata0,      32'hDEAD_BEEF);
    chk("raw_en",     32'(en0),     1);
    chk("raw_hready", 32'(hready0), 1);

    // W=0: write 0x14, then back-to-back reads served from memory
    bus(1'b1, 1'b0, NONSEQ, 1'b1, 32'h14, WORD, 32'd0);
    bus(1'b1, 1'b0, IDLE,   1'b0, 32'h0,  WORD, 32'h1111_1111);
    bus(1'b1, 1'b0, NONSEQ, 1'b0, 32'h10, WORD, 32'd0);
    bus(1'b1, 1'b0, NONSEQ, 1'b0, 32'h14, WORD, 32'd0);
    @(negedge HCLK);
    chk("b2b0_data",   hrdata0,      32'hDEAD_BEEF);
    chk("b2b0_en",     32'(en0),     1);
    chk("b2b0_hready", 32'(hready0), 1);
    bus(1'b1, 1'b0, IDLE, 1'b0, 32'h0, WORD, 32'd0);
    @(negedge HCLK);
    chk("b2b1_data",   hrdata0,      32'h1111_1111);
    chk("b2b1_en",     32'(en0),     1);
    chk("b2b1_hready", 32'(hready0), 1);
    bus(1'b1, 1'b0, IDLE, 1'b0, 32'h0, WORD, 32'd0);
    @(negedge HCLK);
    chk("hold_en",   32'(en0), 0);
    chk("hold_data", hrdata0,  32'h1111_1111);

    // Illegal accesses on W=0: out of range, misaligned, wrong size
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 1'b0, NONSEQ, 1'b0, bad_addr[i], bad_size[i], 32'd0);
      bus(1'b1, 1'b0, IDLE,   1'b0, 32'h0,       WORD,        32'd0);
      @(negedge HCLK);
      chk($sformatf("err1_hready_%0d", i), 32'(hready0), 0);
      chk($sformatf("err1_hresp_%0d", i),  32'(hresp0),  32'(ERROR));
      chk($sformatf("err1_en_%0d", i),     32'(en0),     0);
      @(negedge HCLK);
      chk($sformatf("err2_hready_%0d", i), 32'(hready0), 1);
      chk($sformatf("err2_hresp_%0d", i),  32'(hresp0),  32'(ERROR));
      chk($sformatf("err2_en_%0d", i),     32'(en0),     0);
      @(negedge HCLK);
      chk($sformatf("err_done_hresp_%0d", i), 32'(hresp0), 32'(OKAY));
    end

    // HSEL=0 with a NONSEQ write must not touch memory
    bus(1'b0, 1'b0, NONSEQ, 1'b1, 32'h10, WORD, 32'd0);
    bus(1'b0, 1'b0, IDLE,   1'b0, 32'h0,  WORD, 32'h0000_0000);
    @(negedge HCLK);
    chk("nosel_hready", 32'(hready0), 1);
    chk("nosel_en",     32'(en0),     0);

    // BUSY inside a burst: read 0x10, BUSY, SEQ 0x14, then IDLE
    HBURST = INCR;
    bus(1'b1, 1'b0, NONSEQ, 1'b0, 32'h10, WORD, 32'd0);
    bus(1'b1, 1'b0, BUSY,   1'b0, 32'h14, WORD, 32'd0);
    @(negedge HCLK);
    chk("busy_rd0_data", hrdata0,  32'hDEAD_BEEF);
    chk("busy_rd0_en",   32'(en0), 1);
    bus(1'b1, 1'b0, SEQ, 1'b0, 32'h14, WORD, 32'd0);
    @(negedge HCLK);
    chk("busy_dphase_en",     32'(en0),     0);
    chk("busy_dphase_hready", 32'(hready0), 1);
    bus(1'b1, 1'b0, IDLE, 1'b0, 32'h0, WORD, 32'd0);
    @(negedge HCLK);
    chk("busy_rd1_data", hrdata0,  32'h1111_1111);
    chk("busy_rd1_en",   32'(en0), 1);
    HBURST = SINGLE;

    // W=2: preload words 0..3 with 1..4
    for (int k = 0; k < 4; k++) begin
      bus(1'b0, 1'b1, NONSEQ, 1'b1, 32'(4 * k), WORD, 32'd0);
      bus(1'b0, 1'b1, IDLE,   1'b0, 32'h0,      WORD, 32'(k + 1));
      if (k == 0) begin
        @(negedge HCLK);
        chk("w2_wr_wait_hready", 32'(hready2), 0);
      end
      repeat (2) @(posedge HCLK);
    end

    // W=2: INCR burst of 4; last beat has HSEL dropped during its wait states
    HBURST = INCR;
    bus(1'b0, 1'b1, NONSEQ, 1'b0, 32'h0, WORD, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) bus(1'b0, 1'b1, SEQ,  1'b0, 32'(4 * (k + 1)), WORD, 32'd0);
      else       bus(1'b0, 1'b0, IDLE, 1'b0, 32'h0,            WORD, 32'd0);
      @(negedge HCLK);
      chk($sformatf("burst_w1_hready_%0d", k), 32'(hready2), 0);
      chk($sformatf("burst_w1_en_%0d", k),     32'(en2),     0);
      @(negedge HCLK);
      chk($sformatf("burst_w2_hready_%0d", k), 32'(hready2), 0);
      @(negedge HCLK);
      chk($sformatf("burst_hready_%0d", k), 32'(hready2), 1);
      chk($sformatf("burst_en_%0d", k),     32'(en2),     1);
      chk($sformatf("burst_data_%0d", k),   hrdata2,      32'(k + 1));
    end
    HBURST = SINGLE;

    // W=2: ERROR still takes exactly two cycles
    bus(1'b0, 1'b1, NONSEQ, 1'b0, 32'h100, WORD, 32'd0);
    bus(1'b0, 1'b1, IDLE,   1'b0, 32'h0,   WORD, 32'd0);
    @(negedge HCLK);
    chk("w2_err1_hready", 32'(hready2), 0);
    chk("w2_err1_hresp",  32'(hresp2),  32'(ERROR));
    @(negedge HCLK);
    chk("w2_err2_hready", 32'(hready2), 1);
    chk("w2_err2_hresp",  32'(hresp2),  32'(ERROR));
    @(negedge HCLK);
    chk("w2_err_done_hresp", 32'(hresp2), 32'(OKAY));

    // W=2: reset asserted during a write's wait states
    bus(1'b0, 1'b1, NONSEQ, 1'b1, 32'h0, WORD, 32'd0);
    bus(1'b0, 1'b1, IDLE,   1'b0, 32'h0, WORD, 32'hCAFE_F00D);
    #2;
    HRESET = 1'b1;
    #1;
    chk("rstw_hready2", 32'(hready2), 1);
    chk("rstw_hresp2",  32'(hresp2),  32'(OKAY));
    chk("rstw_hrdata2", hrdata2,      0);
    chk("rstw_en2",     32'(en2),     0);
    chk("rstw_hrdata0", hrdata0,      0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    bus(1'b0, 1'b1, NONSEQ, 1'b0, 32'h0, WORD, 32'd0);
    bus(1'b0, 1'b1, IDLE,   1'b0, 32'h0, WORD, 32'd0);
    repeat (3) @(negedge HCLK);
    chk("rstw_nocommit_data", hrdata2,  32'd1);
    chk("rstw_nocommit_en",   32'(en2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
